// File: rtl/hash_sched_pkg.sv
// Shared constants for the hash table batch scheduler.
//   OPT_READ / OPT_WRITE : request opcodes understood by the table
//   S_IDLE / S_FILL / S_ISSUE : scheduler FSM state encoding
package hash_sched_pkg;

    localparam logic [1:0] OPT_READ  = 2'b00;
    localparam logic [1:0] OPT_WRITE = 2'b01;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;  // batch empty
    localparam state_t S_FILL  = 2'd1;  // 1..NUM_LANES-1 lanes held
    localparam state_t S_ISSUE = 2'd2;  // one cycle driving the table

endpackage

// File: rtl/hash_batch_scheduler_if.sv
// Request stream into the hash batch scheduler (valid/ready handshake).
//   req_valid / req_ready : handshake, transfer when both high
//   req_key, req_value, req_opt, req_tag : request payload
// master drives the payload, slave (the scheduler) drives req_ready.
interface hash_batch_scheduler_if #(
    parameter int unsigned KEY_WIDTH   = 32,
    parameter int unsigned VALUE_WIDTH = 31,
    parameter int unsigned TAG_WIDTH   = 8
);

    logic                   req_valid;
    logic                   req_ready;
    logic [KEY_WIDTH-1:0]   req_key;
    logic [VALUE_WIDTH-1:0] req_value;
    logic [1:0]             req_opt;
    logic [TAG_WIDTH-1:0]   req_tag;

    modport master (
        output req_valid, req_key, req_value, req_opt, req_tag,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_key, req_value, req_opt, req_tag,
        output req_ready
    );

endinterface

// File: rtl/hash_rsp_delay.sv
// Response delay line for the hash batch scheduler. Carries the issued lane
// mask, tags and opts for HT_LATENCY cycles, then captures the table read-out
// into the rsp_* registers, which are valid for exactly one cycle.
//   clk, reset           : clock, synchronous active-high reset
//   issue_mask/tag/opt   : lane mask and per-lane tag/opt, nonzero only on issue
//   ht_rd_out            : table per-lane result, sampled at issue+HT_LATENCY
//   rsp_valid/tag/opt/data : registered per-lane responses
module hash_rsp_delay #(
    parameter int unsigned NUM_LANES  = 8,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned HT_LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_LANES-1:0]            issue_mask,
    input  logic [NUM_LANES*TAG_WIDTH-1:0]  issue_tag,
    input  logic [2*NUM_LANES-1:0]          issue_opt,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] ht_rd_out,
    output logic [NUM_LANES-1:0]            rsp_valid,
    output logic [NUM_LANES*TAG_WIDTH-1:0]  rsp_tag,
    output logic [2*NUM_LANES-1:0]          rsp_opt,
    output logic [NUM_LANES*DATA_WIDTH-1:0] rsp_data
);

    logic [NUM_LANES-1:0]            mask_q [HT_LATENCY];
    logic [NUM_LANES*TAG_WIDTH-1:0]  tag_q  [HT_LATENCY];
    logic [2*NUM_LANES-1:0]          opt_q  [HT_LATENCY];
    logic [NUM_LANES*DATA_WIDTH-1:0] data_d;

    // Only lanes that were issued take the table output; the rest read as zero.
    always_comb begin
        data_d = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (mask_q[HT_LATENCY-1][i]) begin
                data_d[i*DATA_WIDTH +: DATA_WIDTH] = ht_rd_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < HT_LATENCY; s++) begin
                mask_q[s] <= '0;
                tag_q[s]  <= '0;
                opt_q[s]  <= '0;
            end
            rsp_valid <= '0;
            rsp_tag   <= '0;
            rsp_opt   <= '0;
            rsp_data  <= '0;
        end else begin
            mask_q[0] <= issue_mask;
            tag_q[0]  <= issue_tag;
            opt_q[0]  <= issue_opt;
            for (int unsigned s = 1; s < HT_LATENCY; s++) begin
                mask_q[s] <= mask_q[s-1];
                tag_q[s]  <= tag_q[s-1];
                opt_q[s]  <= opt_q[s-1];
            end
            rsp_valid <= mask_q[HT_LATENCY-1];
            rsp_tag   <= tag_q[HT_LATENCY-1];
            rsp_opt   <= opt_q[HT_LATENCY-1];
            rsp_data  <= data_d;
        end
    end

endmodule

// File: rtl/hash_batch_scheduler.sv
// Front-end scheduler for the multi-lane hash table. Packs single requests
// into NUM_LANES-wide batches, issues a batch to the table in one cycle and
// returns tagged per-lane responses after the table read latency. A batch
// closes early when a new request's key matches a held lane.
//   clk, reset  : clock, synchronous active-high reset
//   req         : request stream (slave side)
//   flush       : force issue of a non-empty partial batch
//   ht_*        : lane-parallel table port, driven only in the issue cycle
//   ht_rd_out   : table per-lane read-out
//   rsp_*       : per-lane responses, one-cycle strobe
module hash_batch_scheduler
    import hash_sched_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 8,
    parameter int unsigned KEY_WIDTH   = 32,
    parameter int unsigned VALUE_WIDTH = 31,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned TIMEOUT     = 15,
    parameter int unsigned HT_LATENCY  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    hash_batch_scheduler_if.slave            req,
    input  logic                             flush,
    output logic [NUM_LANES*KEY_WIDTH-1:0]   ht_key,
    output logic [NUM_LANES*VALUE_WIDTH-1:0] ht_value,
    output logic [2*NUM_LANES-1:0]           ht_opt,
    output logic [NUM_LANES-1:0]             ht_en,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  ht_rd_out,
    output logic [NUM_LANES-1:0]             rsp_valid,
    output logic [NUM_LANES*TAG_WIDTH-1:0]   rsp_tag,
    output logic [2*NUM_LANES-1:0]           rsp_opt,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  rsp_data
);

    localparam int unsigned    CNT_W     = $clog2(NUM_LANES + 1);
    localparam int unsigned    AGE_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX   = AGE_W'(TIMEOUT);

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               fill_cnt_q, fill_cnt_d;
    logic [AGE_W-1:0]               age_q, age_d;
    logic [NUM_LANES-1:0]           mask_q, mask_d;
    logic [NUM_LANES*KEY_WIDTH-1:0]   key_q, key_d;
    logic [NUM_LANES*VALUE_WIDTH-1:0] value_q, value_d;
    logic [2*NUM_LANES-1:0]         opt_q, opt_d;
    logic [NUM_LANES*TAG_WIDTH-1:0] tag_q, tag_d;

    logic key_hit;
    logic can_take;
    logic accept;
    logic conflict;
    logic in_issue;

    // One comparator per lane; empty lanes never match.
    always_comb begin
        key_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (mask_q[i] && (key_q[i*KEY_WIDTH +: KEY_WIDTH] == req.req_key)) begin
                key_hit = 1'b1;
            end
        end
    end

    assign can_take      = !reset && ((state_q == S_IDLE) || (state_q == S_FILL));
    assign req.req_ready = can_take && !key_hit;
    assign accept        = req.req_valid && req.req_ready;
    assign conflict      = req.req_valid && key_hit && (state_q == S_FILL);
    assign in_issue      = (state_q == S_ISSUE);

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        age_d      = age_q;
        mask_d     = mask_q;
        key_d      = key_q;
        value_d    = value_q;
        opt_d      = opt_q;
        tag_d      = tag_q;

        // Lanes fill in order, so the next free lane is fill_cnt.
        if (accept) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (fill_cnt_q == CNT_W'(i)) begin
                    mask_d[i]                              = 1'b1;
                    key_d[i*KEY_WIDTH +: KEY_WIDTH]        = req.req_key;
                    value_d[i*VALUE_WIDTH +: VALUE_WIDTH]  = req.req_value;
                    opt_d[2*i +: 2]                        = req.req_opt;
                    tag_d[i*TAG_WIDTH +: TAG_WIDTH]        = req.req_tag;
                end
            end
            fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    age_d   = AGE_W'(1);
                    state_d = (NUM_LANES == 1) ? S_ISSUE : S_FILL;
                end
            end
            S_FILL: begin
                age_d = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);
                // A conflicting request is left waiting and retried after the issue.
                if ((accept && (fill_cnt_q == LAST_LANE)) || conflict ||
                    (age_q == AGE_MAX) || flush) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d    = S_IDLE;
                fill_cnt_d = '0;
                age_d      = '0;
                mask_d     = '0;
                key_d      = '0;
                value_d    = '0;
                opt_d      = {NUM_LANES{OPT_READ}};
                tag_d      = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fill_cnt_q <= '0;
            age_q      <= '0;
            mask_q     <= '0;
            key_q      <= '0;
            value_q    <= '0;
            opt_q      <= {NUM_LANES{OPT_READ}};
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            age_q      <= age_d;
            mask_q     <= mask_d;
            key_q      <= key_d;
            value_q    <= value_d;
            opt_q      <= opt_d;
            tag_q      <= tag_d;
        end
    end

    // Table port shows the batch registers only during the issue cycle.
    assign ht_en    = in_issue ? mask_q  : '0;
    assign ht_key   = in_issue ? key_q   : '0;
    assign ht_value = in_issue ? value_q : '0;
    assign ht_opt   = in_issue ? opt_q   : '0;

    hash_rsp_delay #(
        .NUM_LANES  (NUM_LANES),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .HT_LATENCY (HT_LATENCY)
    ) u_rsp_delay (
        .clk        (clk),
        .reset      (reset),
        .issue_mask (ht_en),
        .issue_tag  (in_issue ? tag_q : '0),
        .issue_opt  (ht_opt),
        .ht_rd_out  (ht_rd_out),
        .rsp_valid  (rsp_valid),
        .rsp_tag    (rsp_tag),
        .rsp_opt    (rsp_opt),
        .rsp_data   (rsp_data)
    );

endmodule

// File: tb/tb_hash_batch_scheduler.sv
module tb_hash_batch_scheduler;
    import hash_sched_pkg::*;

    localparam int NL  = 8;
    localparam int KW  = 32;
    localparam int VW  = 31;
    localparam int DW  = 64;
    localparam int TW  = 8;
    localparam int TO  = 15;
    localparam int LAT = 4;

    typedef struct {
        logic [NL-1:0]    mask;
        logic [NL*KW-1:0] key;
        logic [NL*VW-1:0] value;
        logic [2*NL-1:0]  opt;
        logic [NL*TW-1:0] tag;
        int               issue_cyc;
    } batch_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [NL*KW-1:0] ht_key;
    logic [NL*VW-1:0] ht_value;
    logic [2*NL-1:0]  ht_opt;
    logic [NL-1:0]    ht_en;
    logic [NL*DW-1:0] ht_rd_out;
    logic [NL-1:0]    rsp_valid;
    logic [NL*TW-1:0] rsp_tag;
    logic [2*NL-1:0]  rsp_opt;
    logic [NL*DW-1:0] rsp_data;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int rsp_seen = 0;
    batch_t iss_q[$];
    batch_t rsp_q[$];
    batch_t cur;

    hash_batch_scheduler_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TAG_WIDTH(TW)) req_if ();

    hash_batch_scheduler #(
        .NUM_LANES   (NL),
        .KEY_WIDTH   (KW),
        .VALUE_WIDTH (VW),
        .DATA_WIDTH  (DW),
        .TAG_WIDTH   (TW),
        .TIMEOUT     (TO),
        .HT_LATENCY  (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req_if),
        .flush     (flush),
        .ht_key    (ht_key),
        .ht_value  (ht_value),
        .ht_opt    (ht_opt),
        .ht_en     (ht_en),
        .ht_rd_out (ht_rd_out),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_opt   (rsp_opt),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Table model: each lane returns a word stamped with the current cycle.
    function automatic logic [63:0] rd_word(input int c, input int l);
        return {32'(c), 32'h5A00_0000 | 32'(l)};
    endfunction

    always_comb begin
        ht_rd_out = '0;
        for (int i = 0; i < NL; i++) ht_rd_out[i*DW +: DW] = rd_word(cyc, i);
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic clr();
        cur.mask = '0; cur.key = '0; cur.value = '0; cur.opt = '0; cur.tag = '0;
        cur.issue_cyc = 0;
    endtask

    task automatic commit(input int ic, input bit with_rsp);
        cur.issue_cyc = ic;
        iss_q.push_back(cur);
        if (with_rsp) rsp_q.push_back(cur);
    endtask

    // Present one request until accepted; returns the accept cycle.
    task automatic send_add(input int lane, input logic [KW-1:0] k, input logic [VW-1:0] v,
                            input logic [1:0] o, input logic [TW-1:0] t, input logic fl,
                            output int acc);
        int n;
        req_if.req_valid = 1'b1;
        req_if.req_key   = k;
        req_if.req_value = v;
        req_if.req_opt   = o;
        req_if.req_tag   = t;
        flush            = fl;
        n = 0;
        @(negedge clk);
        while (req_if.req_ready !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (req_if.req_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: req_ready=%b, expected 1 within 40 cycles",
                     req_if.req_ready);
            acc = -1;
        end else begin
            acc = cyc;
        end
        @(posedge clk);
        #1;
        req_if.req_valid = 1'b0;
        flush            = 1'b0;
        cur.mask[lane]              = 1'b1;
        cur.key[lane*KW +: KW]      = k;
        cur.value[lane*VW +: VW]    = v;
        cur.opt[2*lane +: 2]        = o;
        cur.tag[lane*TW +: TW]      = t;
    endtask

    // Monitor: table-port issues and response strobes against the queues.
    always @(negedge clk) begin
        batch_t b;
        logic [NL*DW-1:0] exp_data;
        if (reset === 1'b0 && (|ht_en) === 1'b1) begin
            if (iss_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: ht_en=%h, expected no issue", ht_en);
            end else begin
                b = iss_q.pop_front();
                check("issue_cycle", cyc, b.issue_cyc);
                check("ht_en", ht_en, b.mask);
                check("ht_key", ht_key, b.key);
                check("ht_value", ht_value, b.value);
                check("ht_opt", ht_opt, b.opt);
            end
        end
        if ((|rsp_valid) === 1'b1) begin
            rsp_seen++;
            if (rsp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: rsp_valid=%h, expected no response", rsp_valid);
            end else begin
                b = rsp_q.pop_front();
                exp_data = '0;
                for (int i = 0; i < NL; i++) begin
                    if (b.mask[i]) exp_data[i*DW +: DW] = rd_word(b.issue_cyc + LAT, i);
                end
                check("rsp_cycle", cyc, b.issue_cyc + LAT + 1);
                check("rsp_valid", rsp_valid, b.mask);
                check("rsp_tag", rsp_tag, b.tag);
                check("rsp_opt", rsp_opt, b.opt);
                check("rsp_data", rsp_data, exp_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int a0, a, rsp_snap;
        reset = 1'b1;
        flush = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_key   = '0;
        req_if.req_value = '0;
        req_if.req_opt   = '0;
        req_if.req_tag   = '0;
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_if.req_ready, 1'b0);
        check("rst_ht_en", ht_en, '0);
        check("rst_ht_key", ht_key, '0);
        check("rst_ht_opt", ht_opt, '0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_rsp_tag", rsp_tag, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", req_if.req_ready, 1'b1);
        @(posedge clk);
        #1;

        // 8 back-to-back writes: full batch issues the cycle after the 8th accept.
        clr();
        for (int i = 0; i < 8; i++) begin
            send_add(i, KW'(i), VW'(100 + i), OPT_WRITE, TW'(i), 1'b0, a);
            if (i == 0) a0 = a;
        end
        check("full_last_accept", a, a0 + 7);
        commit(a0 + 8, 1'b1);

        // 3 reads then idle: age reaches TIMEOUT TO cycles after the first FILL cycle.
        clr();
        send_add(0, 32'd1, '0, OPT_READ, 8'h10, 1'b0, a);
        a0 = a;
        send_add(1, 32'd2, '0, OPT_READ, 8'h11, 1'b0, a);
        send_add(2, 32'd3, '0, OPT_READ, 8'h12, 1'b0, a);
        commit(a0 + TO + 1, 1'b1);
        repeat (22) @(posedge clk);
        #1;

        // Keys 5,6,5: second key 5 conflicts and closes the batch.
        clr();
        send_add(0, 32'd5, VW'(55), OPT_WRITE, 8'h20, 1'b0, a);
        a0 = a;
        send_add(1, 32'd6, VW'(66), OPT_WRITE, 8'h21, 1'b0, a);
        commit(a0 + 3, 1'b1);
        req_if.req_valid = 1'b1;
        req_if.req_key   = 32'd5;
        @(negedge clk);
        check("conflict_ready_low", req_if.req_ready, 1'b0);
        @(posedge clk);
        #1;
        clr();
        send_add(0, 32'd5, VW'(77), OPT_READ, 8'h22, 1'b0, a);
        check("conflict_reaccept_cycle", a, a0 + 4);

        // Two more requests, the last with flush: all accepted, issue next cycle.
        a0 = a;
        send_add(1, 32'h77, VW'(7), 2'b10, 8'h23, 1'b0, a);
        send_add(2, 32'h78, VW'(8), 2'b11, 8'h24, 1'b1, a);
        check("flush_accept_cycle", a, a0 + 2);
        commit(a + 1, 1'b1);
        repeat (10) @(posedge clk);
        #1;

        // 16 writes: two full batches issued 9 cycles apart.
        clr();
        for (int i = 0; i < 8; i++) begin
            send_add(i, KW'(i), VW'(32'h1000 + i), OPT_WRITE, TW'(8'h30 + i), 1'b0, a);
            if (i == 0) a0 = a;
        end
        commit(a0 + 8, 1'b1);
        clr();
        for (int i = 8; i < 16; i++) begin
            send_add(i - 8, KW'(i), VW'(32'h1000 + i), OPT_WRITE, TW'(8'h30 + i), 1'b0, a);
        end
        commit(a0 + 17, 1'b1);
        repeat (12) @(posedge clk);
        #1;

        // Reset two cycles after an issue drops the in-flight responses.
        clr();
        for (int i = 0; i < 8; i++) begin
            send_add(i, KW'(32'h40 + i), VW'(i), OPT_WRITE, TW'(8'h50 + i), 1'b0, a);
            if (i == 0) a0 = a;
        end
        commit(a0 + 8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rsp_snap = rsp_seen;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", req_if.req_ready, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        check("no_rsp_after_reset", rsp_seen, rsp_snap);

        for (int n = 0; n < 100 && (iss_q.size() != 0 || rsp_q.size() != 0); n++) begin
            @(posedge clk);
        end
        check("issues_drained", iss_q.size(), 0);
        check("rsps_drained", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
